// File: rtl/opt_generator.sv
// opt_generator: assembles one annealing move command {com, K, L, r_metropolis, r_exchange}
// from three consecutive random words, rejecting move words the downstream stages cannot use.
module opt_generator #(
   parameter int city_num = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        rnd_valid,
   output logic        rnd_ready,
   input  logic [31:0] rnd_data,
   output logic        opt_valid,
   input  logic        opt_ready,
   output logic [79:0] opt,
   output logic [15:0] reject_cnt
);

   localparam logic [1:0] COM_THR  = 2'd0;
   localparam logic [1:0] COM_TWO  = 2'd1;
   localparam logic [1:0] COM_OR0  = 2'd2;
   localparam logic [1:0] COM_OR1  = 2'd3;
   localparam logic [6:0] CITY_MAX = 7'(city_num - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GET_KL = 3'd1,
      GET_RM = 3'd2,
      GET_RE = 3'd3,
      OUT    = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  w_com;
   logic [6:0]  w_kc;
   logic [6:0]  w_lc;
   logic [6:0]  w_hi;
   logic [6:0]  w_lo;
   logic [6:0]  w_diff;
   logic        w_range_ok;
   logic        w_reject;
   logic        w_xfer;
   logic [15:0] w_cmd_kl;
   logic [79:0] r_opt;
   logic [15:0] r_reject_cnt;

   assign w_com  = rnd_data[1:0];
   assign w_kc   = rnd_data[14:8];
   assign w_lc   = rnd_data[22:16];
   assign rnd_ready = (r_state == GET_KL) || (r_state == GET_RM) || (r_state == GET_RE);
   assign w_xfer    = rnd_valid & rnd_ready;
   assign opt_valid = (r_state == OUT);
   assign opt        = r_opt;
   assign reject_cnt = r_reject_cnt;

   // Move-word legality check and K/L ordering (TWO/OR0: K < L, OR1: K > L + 1).
   always_comb begin
      w_hi     = w_kc;
      w_lo     = w_lc;
      w_reject = 1'b1;
      w_cmd_kl = 16'd0;
      if (w_kc >= w_lc) begin
         w_hi = w_kc;
         w_lo = w_lc;
      end else begin
         w_hi = w_lc;
         w_lo = w_kc;
      end
      w_diff     = w_hi - w_lo;
      w_range_ok = (w_kc >= 7'd1) && (w_kc <= CITY_MAX) && (w_lc >= 7'd1) && (w_lc <= CITY_MAX);
      case (w_com)
         COM_TWO, COM_OR0: begin
            w_reject = !w_range_ok || (w_diff == 7'd0);
            w_cmd_kl = {w_com, w_lo, w_hi};
         end
         COM_OR1: begin
            w_reject = !w_range_ok || (w_diff <= 7'd1);
            w_cmd_kl = {w_com, w_hi, w_lo};
         end
         default: begin
            w_reject = 1'b1;
            w_cmd_kl = 16'd0;
         end
      endcase
   end

   // Next-state logic; a rejected move word keeps the FSM in GET_KL.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (run) w_next = GET_KL;
            else     w_next = IDLE;
         end
         GET_KL: begin
            if (rnd_valid && !w_reject) w_next = GET_RM;
            else                        w_next = GET_KL;
         end
         GET_RM: begin
            if (rnd_valid) w_next = GET_RE;
            else           w_next = GET_RM;
         end
         GET_RE: begin
            if (rnd_valid) w_next = OUT;
            else           w_next = GET_RE;
         end
         OUT: begin
            if (opt_ready) w_next = run ? GET_KL : IDLE;
            else           w_next = OUT;
         end
         default: w_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Command fields load only on their own accepted word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_opt <= 80'd0;
      end else if (w_xfer) begin
         case (r_state)
            GET_KL: if (!w_reject) r_opt[79:64] <= w_cmd_kl;
            GET_RM: r_opt[63:32] <= rnd_data;
            GET_RE: r_opt[31:0]  <= rnd_data;
            default: r_opt <= r_opt;
         endcase
      end
   end

   // Saturating reject counter, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_reject_cnt <= 16'd0;
      end else if (w_xfer && (r_state == GET_KL) && w_reject && (r_reject_cnt != 16'hFFFF)) begin
         r_reject_cnt <= r_reject_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_opt_generator.sv
// tb_opt_generator: directed timing checks plus randomized word streams compared
// against a behavioural move-decoding model.
module tb_opt_generator;

   localparam int CITY_NUM = 30;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        rnd_valid;
   logic        rnd_ready;
   logic [31:0] rnd_data;
   logic        opt_valid;
   logic        opt_ready;
   logic [79:0] opt;
   logic [15:0] reject_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int rej_exp  = 0;

   opt_generator #(.city_num(CITY_NUM)) dut (
      .clk(clk), .reset(reset), .run(run),
      .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
      .opt_valid(opt_valid), .opt_ready(opt_ready), .opt(opt),
      .reject_cnt(reject_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: returns 1 and the {com,K,L} field for a usable move word, else 0.
   function automatic bit ref_move(input logic [31:0] word, output logic [15:0] kl);
      int com, k, l, lo, hi;
      com = int'(word & 32'h3);
      k   = int'((word >> 8) & 32'h7F);
      l   = int'((word >> 16) & 32'h7F);
      lo  = (k < l) ? k : l;
      hi  = (k < l) ? l : k;
      kl  = 16'h0;
      if (com == 0) return 1'b0;
      if (k < 1 || k > CITY_NUM - 1 || l < 1 || l > CITY_NUM - 1) return 1'b0;
      if (com == 3) begin
         if (hi - lo <= 1) return 1'b0;
         kl = {2'(com), 7'(hi), 7'(lo)};
      end else begin
         if (k == l) return 1'b0;
         kl = {2'(com), 7'(lo), 7'(hi)};
      end
      return 1'b1;
   endfunction

   // Presents words back-to-back until opt_valid; checks cycle span and the command.
   task automatic direct_cmd(input string tag, input logic [31:0] w[$], input logic [79:0] exp_opt,
                             input int exp_span, input int drop_after);
      int idx = 0;
      int span = 0;
      int guard = 0;
      bit started = 1'b0;
      run = 1'b1;
      opt_ready = 1'b0;
      while (!opt_valid && guard < 200) begin
         if (rnd_ready) started = 1'b1;
         if (started) span++;
         rnd_valid = (idx < w.size());
         rnd_data  = rnd_valid ? w[idx] : 32'h0;
         if (rnd_valid && rnd_ready) begin
            idx++;
            if (idx == drop_after) run = 1'b0;
         end
         @(negedge clk);
         guard++;
      end
      rnd_valid = 1'b0;
      chk_eq({tag, "_valid"}, 80'(opt_valid), 80'd1);
      chk_eq({tag, "_span"}, 80'(span), 80'(exp_span));
      chk_eq({tag, "_used"}, 80'(idx), 80'(w.size()));
      chk_eq({tag, "_opt"}, opt, exp_opt);
   endtask

   task automatic handshake();
      rnd_valid = 1'b0;
      opt_ready = 1'b1;
      @(negedge clk);
      opt_ready = 1'b0;
   endtask

   task automatic gen_stream(input int ncmd, output logic [31:0] q[$]);
      int made = 0;
      logic [31:0] w;
      logic [15:0] kl;
      q = {};
      while (made < ncmd) begin
         w = $urandom;
         w[1:0]   = 2'($urandom_range(0, 3));
         w[14:8]  = 7'($urandom_range(0, 31));
         w[22:16] = 7'($urandom_range(0, 31));
         q.push_back(w);
         if (ref_move(w, kl)) begin
            q.push_back($urandom);
            q.push_back($urandom);
            made++;
         end
      end
   endtask

   // Random rnd_valid / opt_ready; every command popped is compared to the model queue.
   task automatic run_stream(input string tag, input logic [31:0] w[$], input int vpct, input int rpct);
      logic [79:0] expq[$];
      logic [15:0] kl;
      logic [31:0] rm;
      int stage = 0;
      int idx = 0;
      int got = 0;
      int cyc = 0;
      int ncmd;
      for (int i = 0; i < w.size(); i++) begin
         if (stage == 0) begin
            if (ref_move(w[i], kl)) stage = 1;
            else rej_exp = (rej_exp < 65535) ? rej_exp + 1 : 65535;
         end else if (stage == 1) begin
            rm = w[i];
            stage = 2;
         end else begin
            expq.push_back({kl, rm, w[i]});
            stage = 0;
         end
      end
      ncmd = expq.size();
      run = 1'b1;
      while (got < ncmd && cyc < 20000) begin
         rnd_valid = (idx < w.size()) && ($urandom_range(0, 99) < vpct);
         rnd_data  = (idx < w.size()) ? w[idx] : 32'h0;
         if (rnd_valid && rnd_ready) idx++;
         opt_ready = ($urandom_range(0, 99) < rpct);
         if (opt_valid && opt_ready) begin
            chk_eq({tag, "_cmd"}, opt, (expq.size() > 0) ? expq.pop_front() : 80'hX);
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      rnd_valid = 1'b0;
      opt_ready = 1'b0;
      chk_eq({tag, "_count"}, 80'(got), 80'(ncmd));
      chk_eq({tag, "_used"}, 80'(idx), 80'(w.size()));
      @(negedge clk);
      chk_eq({tag, "_rejects"}, 80'(reject_cnt), 80'(rej_exp));
   endtask

   initial begin
      logic [31:0] wq[$];
      reset = 1'b1;
      run = 1'b0;
      rnd_valid = 1'b0;
      rnd_data = 32'h0;
      opt_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      rnd_valid = 1'b1;
      rnd_data = 32'h0014_0501;
      @(negedge clk);
      chk_eq("rst_rnd_ready", 80'(rnd_ready), 80'd0);
      chk_eq("rst_opt_valid", 80'(opt_valid), 80'd0);
      chk_eq("rst_opt", opt, 80'd0);
      chk_eq("rst_reject_cnt", 80'(reject_cnt), 80'd0);
      @(negedge clk);
      chk_eq("idle_rnd_ready", 80'(rnd_ready), 80'd0);

      wq = '{32'h0014_0501, 32'hDEADBEEF, 32'h12345678};
      direct_cmd("basic", wq, {2'd1, 7'd5, 7'd20, 32'hDEADBEEF, 32'h12345678}, 3, -1);
      chk_eq("basic_rejects", 80'(reject_cnt), 80'd0);

      // Backpressure: opt held, no word taken while a word is offered.
      rnd_valid = 1'b1;
      rnd_data  = 32'h0005_1402;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_eq("bp_opt", opt, {2'd1, 7'd5, 7'd20, 32'hDEADBEEF, 32'h12345678});
         chk_eq("bp_rnd_ready", 80'(rnd_ready), 80'd0);
      end
      opt_ready = 1'b1;
      @(negedge clk);
      opt_ready = 1'b0;
      chk_eq("bp_next_ready", 80'(rnd_ready), 80'd1);
      wq = '{32'h0005_1402, 32'h0000_0001, 32'hFFFF_FFFF};
      direct_cmd("or0", wq, {2'd2, 7'd5, 7'd20, 32'h0000_0001, 32'hFFFF_FFFF}, 3, -1);
      handshake();

      wq = '{32'h0005_1403, 32'h1111_2222, 32'h3333_4444};
      direct_cmd("or1_keep", wq, {2'd3, 7'd20, 7'd5, 32'h1111_2222, 32'h3333_4444}, 3, -1);
      handshake();
      wq = '{32'h0014_0503, 32'h5555_6666, 32'h7777_8888};
      direct_cmd("or1_swap", wq, {2'd3, 7'd20, 7'd5, 32'h5555_6666, 32'h7777_8888}, 3, -1);
      handshake();

      wq = '{32'h0014_0500, 32'h001E_0501, 32'h0014_0001, 32'h0005_0603, 32'h0005_0501,
             32'h0014_0501, 32'hA5A5_A5A5, 32'h5A5A_5A5A};
      direct_cmd("rejects", wq, {2'd1, 7'd5, 7'd20, 32'hA5A5_A5A5, 32'h5A5A_5A5A}, 8, -1);
      chk_eq("rejects_cnt", 80'(reject_cnt), 80'd5);
      rej_exp = 5;
      handshake();

      gen_stream(30, wq);
      run_stream("rand_a", wq, 100, 100);
      gen_stream(30, wq);
      run_stream("rand_b", wq, 50, 40);
      gen_stream(30, wq);
      run_stream("rand_c", wq, 20, 80);

      // Dropping run after the metropolis word still completes the command, then idles.
      @(negedge clk);
      wq = '{32'h0009_0301, 32'h0BAD_0001, 32'h0BAD_0002};
      direct_cmd("rundrop", wq, {2'd1, 7'd3, 7'd9, 32'h0BAD_0001, 32'h0BAD_0002}, 3, 2);
      handshake();
      rnd_valid = 1'b1;
      rnd_data  = 32'h0014_0501;
      chk_eq("rundrop_idle_ready", 80'(rnd_ready), 80'd0);
      repeat (3) @(negedge clk);
      chk_eq("rundrop_still_idle", 80'(rnd_ready), 80'd0);
      chk_eq("rundrop_no_valid", 80'(opt_valid), 80'd0);

      // Reset after one accepted word: outputs clear at once, partial command lost.
      run = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk_eq("mid_in_rm", 80'(rnd_ready), 80'd1);
      rnd_data = 32'hAAAA_5555;
      reset = 1'b1;
      #1;
      chk_eq("mid_rst_valid", 80'(opt_valid), 80'd0);
      chk_eq("mid_rst_opt", opt, 80'd0);
      chk_eq("mid_rst_cnt", 80'(reject_cnt), 80'd0);
      chk_eq("mid_rst_ready", 80'(rnd_ready), 80'd0);
      rnd_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      rej_exp = 0;
      wq = '{32'h0005_1402, 32'h0BAD_F00D, 32'hCAFE_F00D};
      direct_cmd("post_rst", wq, {2'd2, 7'd5, 7'd20, 32'h0BAD_F00D, 32'hCAFE_F00D}, 3, -1);
      handshake();

      // Reject counter saturation.
      rnd_valid = 1'b1;
      rnd_data  = 32'h0014_0500;
      repeat (65534) @(negedge clk);
      chk_eq("sat_below", 80'(reject_cnt), 80'hFFFE);
      repeat (6) @(negedge clk);
      chk_eq("sat_hold", 80'(reject_cnt), 80'hFFFF);
      chk_eq("sat_no_cmd", 80'(opt_valid), 80'd0);
      rnd_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/opt_generator.md
# opt_generator

Builds one `opt_t` move command per annealing step for a replica from an external 32-bit random-word stream. It consumes three words per command: a move word (operation and K/L), `r_metropolis` and `r_exchange`. It normalises or rejects the move word so that K and L always meet the ordering rules the downstream distance/opt stages support (TWO/OR0: K < L; OR1: K > L + 1). It sits between the replica's random number source and the distance-delta stage.

## Interface
Parameters:
- `city_num`, default 30: number of cities. Legal city indices are 1..city_num-1; city 0 is the fixed start. Must be ≤ 127.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `run` in 1: enables generation of new commands.
- `rnd_valid` in 1: random word available.
- `rnd_ready` out 1: block accepts `rnd_data` this cycle.
- `rnd_data` in 32: random word.
- `opt_valid` out 1: `opt` holds a complete command.
- `opt_ready` in 1: downstream accepts `opt`.
- `opt` out 80 (`opt_t`): {com[1:0], K[6:0], L[6:0], r_metropolis[31:0], r_exchange[31:0]}.
- `reject_cnt` out 16: saturating count of rejected move words.

## Operation
- FSM states: IDLE, GET_KL, GET_RM, GET_RE, OUT. Reset state is IDLE.
- IDLE → GET_KL when `run`=1.
- `rnd_ready` is combinational. It is 1 in GET_KL, GET_RM and GET_RE, and 0 in IDLE and OUT.
- A word transfers when `rnd_valid` and `rnd_ready` are both 1.
- GET_KL: decode the transferred word A:
  - com = A[1:0]
  - Kc = A[14:8]
  - Lc = A[22:16]
  - All other bits are ignored.
- Reject the word (stay in GET_KL, increment `reject_cnt`) if any of:
  - com = THR
  - Kc or Lc is outside 1..city_num-1
  - com ∈ {TWO, OR0} and Kc = Lc
  - com = OR1 and |Kc − Lc| ≤ 1
- Otherwise normalise and go to GET_RM:
  - TWO/OR0: K = min(Kc, Lc), L = max(Kc, Lc).
  - OR1: K = max, L = min.
- GET_RM: the transferred word becomes `r_metropolis`; go to GET_RE.
- GET_RE: the transferred word becomes `r_exchange`; go to OUT.
- OUT: `opt_valid`=1, and `opt` is stable until the handshake (`opt_ready`=1). After the handshake go to GET_KL if `run`=1, else IDLE.
- `run` is sampled only in IDLE and at the OUT handshake. Dropping `run` mid-command does not abort the command.
- `opt` register fields load only on the respective accepted words. The `opt` output is valid only while `opt_valid`=1.
- `reject_cnt` saturates at 0xFFFF. Only `reset` clears it.

## Timing
- Reset values:
  - state IDLE
  - `opt_valid` 0
  - `opt` 0
  - `reject_cnt` 0
  - `rnd_ready` 0 (follows from the IDLE state)
- Reset asserted mid-command discards any partial command immediately (asynchronous). No `opt_valid` may follow from pre-reset words.
- Latency: with `rnd_valid` held at 1 and no rejects, `opt_valid` rises in the cycle after the third word transfers.
- Sustained throughput: one command per 4 cycles (3 word cycles + 1 OUT cycle, with `opt_ready`=1).
- Each rejected word adds exactly one cycle.
- `rnd_valid`=0 stalls the FSM in place; no state or register changes.
- A word with `rnd_valid`=1 in OUT or IDLE is not consumed.

## Test plan
- Basic TWO: `run`=1, words 0x0014_0501, 0xDEADBEEF, 0x12345678 → one command `opt` = {TWO, K=5, L=20, 0xDEADBEEF, 0x12345678}. `opt_valid` rises 1 cycle after the third word; `reject_cnt`=0.
- Swap rules:
  - 0x0005_1402 → OR0, K=5, L=20.
  - 0x0005_1403 → OR1, K=20, L=5 (no swap).
  - 0x0014_0503 → OR1, K=20, L=5 (swapped).
- Rejects: 0x0014_0500 (THR), 0x001E_0501 (L=30), 0x0014_0001 (K=0), 0x0005_0603 (OR1 adjacent), 0x0005_0501 (K=L), then 0x0014_0501 → each reject costs one cycle. `reject_cnt`=5. The output is the TWO 5/20 command.
- Backpressure: hold `opt_ready`=0 for 5 cycles in OUT with `rnd_valid`=1 → `opt` stable, `rnd_ready`=0, no word consumed. On `opt_ready`=1 the next word is consumed the following cycle.
- Run/stall: drop `run` after GET_RM → command still completes, then IDLE with `rnd_ready`=0. Toggle `rnd_valid` randomly → the command sequence matches the golden model.
- Reset mid-command: assert `reset` after the first accepted word → all outputs 0 immediately. After release with `run`=1, the first `opt` uses only post-reset words. Also feed 70000 rejects → `reject_cnt` holds at 0xFFFF.
